// File: rtl/decode_issue.sv
// Decode/issue stage: assembles 16/32-bit V850 halfword streams, reads GR and
// drives the executer with registered operands, inserting NOP bubbles as needed.
module decode_issue #(
  parameter logic [9:0] NOP_SEL = 10'b10_0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hw_valid_i,
  input  logic [15:0] hw_i,
  output logic        hw_ready_o,
  input  logic        stall_i,
  output logic [4:0]  gr_raddr1_o,
  output logic [4:0]  gr_raddr2_o,
  input  logic [31:0] gr_rdata1_i,
  input  logic [31:0] gr_rdata2_i,
  output logic [4:0]  destination_o,
  output logic [4:0]  destination2_o,
  output logic [31:0] reg1_o,
  output logic [31:0] reg2_o,
  output logic [31:0] reg3_o,
  output logic        increment_bit_o,
  output logic [9:0]  circuit_sel_o,
  output logic        issue_o,
  output logic        illegal_o
);

  localparam logic [9:0] SEL_ADD = 10'b00_0010_0000;
  localparam logic [9:0] SEL_CMP = 10'd0;
  localparam logic [9:0] SEL_AND = 10'd2;
  localparam logic [9:0] SEL_OR  = 10'd3;

  typedef enum logic [1:0] {FIRST, SECOND, DECODE} state_t;

  state_t      state_q, state_d;
  logic [15:0] hw0_q, hw0_d;
  logic [15:0] imm_q, imm_d;
  logic [4:0]  dest_q, dest_d;
  logic [31:0] reg1_q, reg1_d;
  logic [31:0] reg2_q, reg2_d;
  logic        inc_q, inc_d;
  logic [9:0]  sel_q, sel_d;
  logic        issue_q, issue_d;
  logic        illegal_q, illegal_d;
  logic        sb_valid_q, sb_valid_d;
  logic [4:0]  sb_reg_q, sb_reg_d;

  logic [5:0]  opcode;
  logic [4:0]  f_reg1, f_reg2;
  logic [31:0] op1, op2, sext5, sext16, zext16;
  logic [9:0]  dec_sel;
  logic [31:0] dec_reg1, dec_reg2;
  logic        dec_inc, dec_writes, dec_legal, uses1, uses2, hazard;

  assign opcode = hw0_q[10:5];
  assign f_reg1 = hw0_q[4:0];
  assign f_reg2 = hw0_q[15:11];

  assign gr_raddr1_o = f_reg1;
  assign gr_raddr2_o = f_reg2;

  assign op1    = (f_reg1 == 5'd0) ? 32'd0 : gr_rdata1_i;
  assign op2    = (f_reg2 == 5'd0) ? 32'd0 : gr_rdata2_i;
  assign sext5  = {{27{f_reg1[4]}}, f_reg1};
  assign sext16 = {{16{imm_q[15]}}, imm_q};
  assign zext16 = {16'd0, imm_q};

  always_comb begin
    dec_legal  = 1'b1;
    dec_sel    = SEL_ADD;
    dec_reg1   = op1;
    dec_reg2   = op2;
    dec_inc    = 1'b0;
    dec_writes = 1'b1;
    uses1      = 1'b1;
    uses2      = 1'b1;
    case (opcode)
      6'b001110: ;
      6'b010010: begin dec_reg1 = sext5; uses1 = 1'b0; end
      6'b001101: begin dec_reg1 = ~op1; dec_inc = 1'b1; end
      6'b001111: begin
        dec_sel = SEL_CMP; dec_reg1 = ~op1; dec_inc = 1'b1; dec_writes = 1'b0;
      end
      6'b010011: begin
        dec_sel = SEL_CMP; dec_reg1 = ~sext5; dec_inc = 1'b1; dec_writes = 1'b0;
        uses1 = 1'b0;
      end
      6'b001010: dec_sel = SEL_AND;
      6'b001000: dec_sel = SEL_OR;
      6'b110000: begin dec_reg1 = sext16; dec_reg2 = op1; uses2 = 1'b0; end
      6'b110110: begin
        dec_sel = SEL_AND; dec_reg1 = zext16; dec_reg2 = op1; uses2 = 1'b0;
      end
      default: begin
        dec_legal = 1'b0; dec_writes = 1'b0; uses1 = 1'b0; uses2 = 1'b0;
      end
    endcase
    hazard = sb_valid_q && ((uses1 && (f_reg1 == sb_reg_q)) ||
                            (uses2 && (f_reg2 == sb_reg_q)));
  end

  assign hw_ready_o = (state_q != DECODE);

  // Any gap between issue and the next decode lets write-back finish, so the
  // scoreboard only survives a 16-bit instruction fetched right after an issue.
  always_comb begin
    state_d    = state_q;
    hw0_d      = hw0_q;
    imm_d      = imm_q;
    dest_d     = 5'd0;
    reg1_d     = 32'd0;
    reg2_d     = 32'd0;
    inc_d      = 1'b0;
    sel_d      = NOP_SEL;
    issue_d    = 1'b0;
    illegal_d  = 1'b0;
    sb_valid_d = sb_valid_q;
    sb_reg_d   = sb_reg_q;
    case (state_q)
      FIRST: begin
        if (hw_valid_i) begin
          hw0_d   = hw_i;
          state_d = (hw_i[10:9] == 2'b11) ? SECOND : DECODE;
          if (hw_i[10:9] == 2'b11) sb_valid_d = 1'b0;
        end else begin
          sb_valid_d = 1'b0;
        end
      end
      SECOND: begin
        sb_valid_d = 1'b0;
        if (hw_valid_i) begin
          imm_d   = hw_i;
          state_d = DECODE;
        end
      end
      default: begin
        if (stall_i || (dec_legal && hazard)) begin
          sb_valid_d = 1'b0;
        end else if (!dec_legal) begin
          illegal_d  = 1'b1;
          sb_valid_d = 1'b0;
          state_d    = FIRST;
        end else begin
          dest_d     = f_reg2;
          reg1_d     = dec_reg1;
          reg2_d     = dec_reg2;
          inc_d      = dec_inc;
          sel_d      = dec_sel;
          issue_d    = 1'b1;
          sb_valid_d = dec_writes && (f_reg2 != 5'd0);
          sb_reg_d   = f_reg2;
          state_d    = FIRST;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FIRST;
      hw0_q      <= 16'd0;
      imm_q      <= 16'd0;
      dest_q     <= 5'd0;
      reg1_q     <= 32'd0;
      reg2_q     <= 32'd0;
      inc_q      <= 1'b0;
      sel_q      <= NOP_SEL;
      issue_q    <= 1'b0;
      illegal_q  <= 1'b0;
      sb_valid_q <= 1'b0;
      sb_reg_q   <= 5'd0;
    end else begin
      state_q    <= state_d;
      hw0_q      <= hw0_d;
      imm_q      <= imm_d;
      dest_q     <= dest_d;
      reg1_q     <= reg1_d;
      reg2_q     <= reg2_d;
      inc_q      <= inc_d;
      sel_q      <= sel_d;
      issue_q    <= issue_d;
      illegal_q  <= illegal_d;
      sb_valid_q <= sb_valid_d;
      sb_reg_q   <= sb_reg_d;
    end
  end

  assign destination_o   = dest_q;
  assign destination2_o  = 5'd0;
  assign reg1_o          = reg1_q;
  assign reg2_o          = reg2_q;
  assign reg3_o          = 32'd0;
  assign increment_bit_o = inc_q;
  assign circuit_sel_o   = sel_q;
  assign issue_o         = issue_q;
  assign illegal_o       = illegal_q;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: a small GR array feeds the read ports and
// hand-computed operand/timing expectations are checked at the falling edge.
module tb_decode_issue;

  localparam logic [9:0] NOP_SEL = 10'b10_0000_0000;
  localparam logic [9:0] SEL_ADD = 10'b00_0010_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        hw_valid_i;
  logic [15:0] hw_i;
  logic        hw_ready_o;
  logic        stall_i;
  logic [4:0]  gr_raddr1_o, gr_raddr2_o;
  logic [31:0] gr_rdata1_i, gr_rdata2_i;
  logic [4:0]  destination_o, destination2_o;
  logic [31:0] reg1_o, reg2_o, reg3_o;
  logic        increment_bit_o;
  logic [9:0]  circuit_sel_o;
  logic        issue_o, illegal_o;

  logic [31:0] gr [32];
  int checks = 0;
  int errors = 0;
  int cyc;

  assign gr_rdata1_i = gr[gr_raddr1_o];
  assign gr_rdata2_i = gr[gr_raddr2_o];

  always #5 clk = ~clk;

  decode_issue #(.NOP_SEL(NOP_SEL)) dut (
    .clk(clk), .reset(reset), .hw_valid_i(hw_valid_i), .hw_i(hw_i),
    .hw_ready_o(hw_ready_o), .stall_i(stall_i),
    .gr_raddr1_o(gr_raddr1_o), .gr_raddr2_o(gr_raddr2_o),
    .gr_rdata1_i(gr_rdata1_i), .gr_rdata2_i(gr_rdata2_i),
    .destination_o(destination_o), .destination2_o(destination2_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .reg3_o(reg3_o),
    .increment_bit_o(increment_bit_o), .circuit_sel_o(circuit_sel_o),
    .issue_o(issue_o), .illegal_o(illegal_o)
  );

  function automatic logic [15:0] enc(input logic [5:0] op, input logic [4:0] r1,
                                      input logic [4:0] r2);
    return {r2, op, r1};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called just after a falling edge; returns just after the accepting edge.
  task automatic applyStimulus(input logic [15:0] h);
    hw_valid_i = 1'b1;
    hw_i       = h;
    @(negedge clk);
    hw_valid_i = 1'b0;
  endtask

  task automatic waitIssue(output int cycles);
    cycles = 0;
    while (issue_o !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic checkIssued(input string tag, input logic [9:0] sel,
                             input logic [31:0] r1, input logic [31:0] r2,
                             input logic [4:0] dest, input logic inc);
    checkOutput({tag, ".sel"},  32'(circuit_sel_o), 32'(sel));
    checkOutput({tag, ".reg1"}, reg1_o, r1);
    checkOutput({tag, ".reg2"}, reg2_o, r2);
    checkOutput({tag, ".dest"}, 32'(destination_o), 32'(dest));
    checkOutput({tag, ".inc"},  32'(increment_bit_o), 32'(inc));
  endtask

  task automatic checkNop(input string tag);
    checkOutput({tag, ".issue"}, 32'(issue_o), 32'd0);
    checkOutput({tag, ".sel"},   32'(circuit_sel_o), 32'(NOP_SEL));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) gr[i] = 32'h1000 + 32'(i);
    gr[0] = 32'hDEADBEEF;
    gr[1] = 32'd5;
    gr[2] = 32'd7;
    gr[3] = 32'd1;
    gr[4] = 32'd9;
    gr[7] = 32'd100;
    reset = 1'b1; hw_valid_i = 1'b0; hw_i = 16'd0; stall_i = 1'b0;
    repeat (2) @(negedge clk);
    checkNop("reset");
    checkOutput("reset.illegal", 32'(illegal_o), 32'd0);
    checkOutput("reset.ready", 32'(hw_ready_o), 32'd1);
    checkOutput("reset.reg1", reg1_o, 32'd0);
    checkOutput("reset.dest", 32'(destination_o), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(enc(6'b001110, 5'd1, 5'd2));
    waitIssue(cyc);
    checkOutput("add.latency", 32'(cyc), 32'd1);
    checkIssued("add", SEL_ADD, 32'd5, 32'd7, 5'd2, 1'b0);
    checkOutput("add.dest2", 32'(destination2_o), 32'd0);
    checkOutput("add.reg3", reg3_o, 32'd0);
    @(negedge clk);
    checkNop("add.pulse");

    applyStimulus(enc(6'b001101, 5'd3, 5'd4));
    waitIssue(cyc);
    checkOutput("sub.latency", 32'(cyc), 32'd1);
    checkIssued("sub", SEL_ADD, 32'hFFFFFFFE, 32'd9, 5'd4, 1'b1);
    @(negedge clk);

    applyStimulus(enc(6'b001110, 5'd0, 5'd2));
    waitIssue(cyc);
    checkIssued("add_r0", SEL_ADD, 32'd0, 32'd7, 5'd2, 1'b0);
    @(negedge clk);

    applyStimulus(enc(6'b110000, 5'd1, 5'd5));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkNop("addi.gap");
      checkOutput("addi.ready", 32'(hw_ready_o), 32'd1);
    end
    applyStimulus(16'hFFFF);
    waitIssue(cyc);
    checkOutput("addi.latency", 32'(cyc), 32'd1);
    checkIssued("addi", SEL_ADD, 32'hFFFFFFFF, 32'd5, 5'd5, 1'b0);
    @(negedge clk);

    applyStimulus(enc(6'b110110, 5'd1, 5'd6));
    applyStimulus(16'h8000);
    waitIssue(cyc);
    checkIssued("andi", 10'd2, 32'h00008000, 32'd5, 5'd6, 1'b0);
    @(negedge clk);

    applyStimulus(enc(6'b001110, 5'd1, 5'd2));
    waitIssue(cyc);
    applyStimulus(enc(6'b001110, 5'd2, 5'd3));
    checkNop("haz.fetch");
    waitIssue(cyc);
    checkOutput("haz.latency", 32'(cyc), 32'd2);
    checkIssued("haz", SEL_ADD, 32'd7, 32'd1, 5'd3, 1'b0);
    @(negedge clk);

    applyStimulus(enc(6'b001111, 5'd1, 5'd2));
    waitIssue(cyc);
    checkIssued("cmp", 10'd0, 32'hFFFFFFFA, 32'd7, 5'd2, 1'b1);
    applyStimulus(enc(6'b001110, 5'd2, 5'd3));
    waitIssue(cyc);
    checkOutput("cmp_nohaz.latency", 32'(cyc), 32'd1);
    @(negedge clk);

    applyStimulus(enc(6'b000001, 5'd1, 5'd2));
    checkOutput("ill.early", 32'(illegal_o), 32'd0);
    @(negedge clk);
    checkOutput("ill.pulse", 32'(illegal_o), 32'd1);
    checkNop("ill");
    @(negedge clk);
    checkOutput("ill.end", 32'(illegal_o), 32'd0);
    applyStimulus(enc(6'b010010, 5'b11110, 5'd7));
    waitIssue(cyc);
    checkOutput("imm5.latency", 32'(cyc), 32'd1);
    checkIssued("imm5", SEL_ADD, 32'hFFFFFFFE, 32'd100, 5'd7, 1'b0);
    @(negedge clk);

    applyStimulus(enc(6'b110000, 5'd1, 5'd5));
    reset = 1'b1;
    #1;
    checkNop("rst_mid");
    checkOutput("rst_mid.ready", 32'(hw_ready_o), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(enc(6'b001110, 5'd1, 5'd2));
    waitIssue(cyc);
    checkOutput("rst_add.latency", 32'(cyc), 32'd1);
    checkIssued("rst_add", SEL_ADD, 32'd5, 32'd7, 5'd2, 1'b0);

    stall_i = 1'b1;
    applyStimulus(enc(6'b001110, 5'd2, 5'd3));
    @(negedge clk);
    checkNop("stallhaz");
    stall_i = 1'b0;
    waitIssue(cyc);
    checkOutput("stallhaz.latency", 32'(cyc), 32'd1);
    @(negedge clk);

    stall_i = 1'b1;
    applyStimulus(enc(6'b001000, 5'd3, 5'd4));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkNop("stall");
    end
    stall_i = 1'b0;
    waitIssue(cyc);
    checkOutput("stall.latency", 32'(cyc), 32'd1);
    checkIssued("or", 10'd3, 32'd1, 32'd9, 5'd4, 1'b0);
    @(negedge clk);
    checkNop("stall.once");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
